// File: rtl/sop_pkg.sv
// Shared types and helpers for the programmable sum-of-products sweeper.
//   sop_state_t : sweeper FSM states
//   N_IN_MAX    : largest supported input count
//   bin2gray    : reflected Gray code of an N_IN_MAX-bit value
package sop_pkg;

  localparam int unsigned N_IN_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sop_state_t;

  // Callers zero-extend narrower indices; the low bits of the result are then
  // the Gray code of the narrow value.
  function automatic logic [N_IN_MAX-1:0] bin2gray(input logic [N_IN_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sop_lut.sv
// Minterm mask register plus index -> output lookup.
//   clk, reset : clock, synchronous active-high reset (clears the mask)
//   load       : load mask_in at the edge (gating supplied by the parent)
//   mask_in    : new minterm mask, bit k = f(k)
//   idx        : input combination to evaluate
//   s          : f(idx) = mask[idx]
module sop_lut #(
  parameter  int unsigned N_IN   = 4,
  localparam int unsigned MASK_W = 2 ** N_IN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [MASK_W-1:0] mask_in,
  input  logic [N_IN-1:0]   idx,
  output logic              s
);

  logic [MASK_W-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
    end else if (load) begin
      mask_q <= mask_in;
    end
  end

  assign s = mask_q[idx];

endmodule

// File: rtl/sop_sweep.sv
// Truth-table sweeper: walks every input combination of a programmable
// sum-of-products function and streams (index, output) pairs over valid/ready,
// counting the minterms that evaluate true.
// Optional: define SOP_SWEEP_GRAY_EN to visit combinations in reflected
// Gray-code order instead of binary order.
//   clk, reset : clock, synchronous active-high reset
//   cfg_we     : load cfg_mask (honoured in IDLE only)
//   cfg_mask   : minterm mask, bit k = f(k)
//   start      : begin a sweep (honoured in IDLE only)
//   busy       : high in RUN or DONE
//   out_valid  : (out_idx, out_s) valid, high exactly while in RUN
//   out_ready  : consumer accepts the pair
//   out_idx    : input combination, MSB = first input
//   out_s      : f(out_idx)
//   done       : one-cycle pulse after the final transfer
//   ones_cnt   : accepted pairs with out_s = 1
module sop_sweep
  import sop_pkg::*;
#(
  parameter  int unsigned N_IN   = 4,
  localparam int unsigned MASK_W = 2 ** N_IN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [MASK_W-1:0] cfg_mask,
  input  logic              start,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_IN-1:0]   out_idx,
  output logic              out_s,
  output logic              done,
  output logic [N_IN:0]     ones_cnt
);

  if (N_IN < 1 || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("sop_sweep: N_IN out of range");
  end

  sop_state_t        state_q, state_d;
  logic [N_IN-1:0]   cnt_q, cnt_d;
  logic [N_IN:0]     ones_q, ones_d;
  logic [N_IN-1:0]   idx_sel;
  logic              lut_s;
  logic              in_run;

`ifdef SOP_SWEEP_GRAY_EN
  assign idx_sel = N_IN'(bin2gray(N_IN_MAX'(cnt_q)));
`else
  assign idx_sel = cnt_q;
`endif

  // Mask only changes in IDLE so it is stable for the whole sweep.
  sop_lut #(
    .N_IN (N_IN)
  ) u_lut (
    .clk     (clk),
    .reset   (reset),
    .load    (cfg_we && (state_q == IDLE)),
    .mask_in (cfg_mask),
    .idx     (idx_sel),
    .s       (lut_s)
  );

  assign in_run    = (state_q == RUN);
  assign out_valid = in_run;
  assign out_idx   = in_run ? idx_sel : '0;
  assign out_s     = in_run ? lut_s : 1'b0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign ones_cnt  = ones_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          ones_d  = '0;
        end
      end
      RUN: begin
        if (out_ready) begin
          ones_d = ones_q + (N_IN + 1)'(lut_s);
          // MASK_W-1 is all ones for the counter width.
          if (cnt_q == '1) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + N_IN'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sop_sweep.sv
// Self-checking bench for sop_sweep: stimulus pushes expected (idx, s) pairs
// into a scoreboard queue; a monitor pops and compares on every transfer.
module tb_sop_sweep;

`ifdef SOP_SWEEP_GRAY_EN
  localparam int unsigned N = 3;
`else
  localparam int unsigned N = 4;
`endif
  localparam int unsigned MW = 2 ** N;

  typedef struct {
    int idx;
    int s;
  } pair_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [MW-1:0] cfg_mask = '0;
  logic          start = 1'b0;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  out_idx;
  logic          out_s;
  logic          done;
  logic [N:0]    ones_cnt;

  pair_t sb[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    have_prev = 0;
  int    prev_idx = 0;

  sop_sweep #(
    .N_IN (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_mask  (cfg_mask),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_s     (out_s),
    .done      (done),
    .ones_cnt  (ones_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input int s);
    pair_t p;
    p.idx = idx;
    p.s   = s;
    sb.push_back(p);
  endtask

  // Monitor: a transfer is committed at the next rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pair", int'(out_idx), -1);
      end else begin
        pair_t p;
        p = sb.pop_front();
        chk("pair_idx", int'(out_idx), p.idx);
        chk("pair_s", int'(out_s), p.s);
      end
`ifdef SOP_SWEEP_GRAY_EN
      if (have_prev != 0) chk("gray_step", $countones(prev_idx ^ int'(out_idx)), 1);
      have_prev = 1;
      prev_idx  = int'(out_idx);
`endif
    end
  end

  // Starts at the first sample point after the start edge (cycle 1).
  task automatic run_sweep(input int stall_cyc, input int stall_len, input int stall_idx,
                           input int stall_s, input int inj_cyc, input int rst_cyc,
                           output int vcyc, output int dcyc);
    vcyc = 0;
    dcyc = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      cfg_we = 1'b0;
      start  = 1'b0;
      if (cyc >= stall_cyc && cyc < stall_cyc + stall_len) begin
        out_ready = 1'b0;
        chk("stall_idx", int'(out_idx), stall_idx);
        chk("stall_s", int'(out_s), stall_s);
      end else begin
        out_ready = 1'b1;
      end
      if (cyc == inj_cyc) begin
        cfg_we   = 1'b1;
        cfg_mask = '1;
        start    = 1'b1;
      end
      if (out_valid) vcyc++;
      if (done) begin
        dcyc = cyc;
        chk("done_busy", int'(busy), 1);
        return;
      end
      if (cyc == rst_cyc) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        return;
      end
      tick();
    end
    chk("sweep_timeout", dcyc, 0);
  endtask

  task automatic begin_sweep(input logic we, input logic [MW-1:0] m);
    have_prev = 0;
    cfg_we    = we;
    cfg_mask  = m;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic finish_sweep(input string tag, input int vcyc, input int dcyc,
                              input int exp_v, input int exp_d, input int exp_ones);
    chk({tag, "_valid_cycles"}, vcyc, exp_v);
    chk({tag, "_done_cycle"}, dcyc, exp_d);
    chk({tag, "_ones_cnt"}, int'(ones_cnt), exp_ones);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    tick();
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_ones"}, int'(ones_cnt), exp_ones);
  endtask

  initial begin
    int vcyc, dcyc;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_s", int'(out_s), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ones", int'(ones_cnt), 0);

`ifdef SOP_SWEEP_GRAY_EN
    begin
      int gidx[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
      int gs[8]   = '{1, 0, 0, 0, 0, 1, 0, 0};
      for (int i = 0; i < 8; i++) push(gidx[i], gs[i]);
      begin_sweep(1'b1, 8'b1000_0001);
      run_sweep(0, 0, 0, 0, 0, 0, vcyc, dcyc);
      finish_sweep("gray", vcyc, dcyc, 8, 9, 2);
    end
`else
    begin
      int ref_s[16] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1};

      // Reference function, ready tied high.
      for (int i = 0; i < 16; i++) push(i, ref_s[i]);
      begin_sweep(1'b1, 16'hAC3C);
      run_sweep(0, 0, 0, 0, 0, 0, vcyc, dcyc);
      finish_sweep("ref", vcyc, dcyc, 16, 17, 8);

      // Three-cycle stall while idx 5 is presented; mask retained from before.
      for (int i = 0; i < 16; i++) push(i, ref_s[i]);
      begin_sweep(1'b0, '0);
      run_sweep(6, 3, 5, 1, 0, 0, vcyc, dcyc);
      finish_sweep("stall", vcyc, dcyc, 19, 20, 8);

      // cfg_we and start during RUN are ignored.
      for (int i = 0; i < 16; i++) push(i, ref_s[i]);
      begin_sweep(1'b0, '0);
      run_sweep(0, 0, 0, 0, 4, 0, vcyc, dcyc);
      finish_sweep("ignore", vcyc, dcyc, 16, 17, 8);

      // IDLE load of all ones.
      cfg_we   = 1'b1;
      cfg_mask = 16'hFFFF;
      tick();
      cfg_we = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) push(i, 1);
      begin_sweep(1'b0, '0);
      run_sweep(0, 0, 0, 0, 0, 0, vcyc, dcyc);
      finish_sweep("ffff", vcyc, dcyc, 16, 17, 16);

      // Reset while idx 9 is presented.
      for (int i = 0; i < 10; i++) push(i, 1);
      begin_sweep(1'b0, '0);
      run_sweep(0, 0, 0, 0, 0, 10, vcyc, dcyc);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_valid", int'(out_valid), 0);
      chk("midrst_ones", int'(ones_cnt), 0);
      chk("midrst_sb_empty", sb.size(), 0);

      // Mask was cleared by reset.
      for (int i = 0; i < 16; i++) push(i, 0);
      begin_sweep(1'b0, '0);
      run_sweep(0, 0, 0, 0, 0, 0, vcyc, dcyc);
      finish_sweep("zero", vcyc, dcyc, 16, 17, 0);

      // Load and start on the same edge.
      push(0, 1);
      for (int i = 1; i < 16; i++) push(i, 0);
      begin_sweep(1'b1, 16'h0001);
      run_sweep(0, 0, 0, 0, 0, 0, vcyc, dcyc);
      finish_sweep("ldstart", vcyc, dcyc, 16, 17, 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
